imem_port_arbiter: RTL and testbench

IMEM_PORT_ARBITER -- requirements
Module: imem_port_arbiter

---
 rtl/core_pkg.sv | 23 ++
 rtl/imem_port_arbiter.sv | 106 ++++++++++
 tb/tb_imem_port_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// ============================================================================
// Module      : core_pkg
// Description : Shared types and defaults for the instruction-memory port
//               arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_pkg;

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        DRAIN   = 2'd1,
        LOAD    = 2'd2,
        RESTART = 2'd3
    } arb_state_e;

    localparam int unsigned C_DRAIN_CYCLES_DEF = 2;
    localparam int unsigned C_LOAD_CNT_W       = 16;

endpackage

`default_nettype wire

// File: rtl/imem_port_arbiter.sv
// ============================================================================
// Module      : imem_port_arbiter
// Description : Shares the instruction-memory port between the frontend fetch
//               path and a debug program loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_port_arbiter
    import core_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int DRAIN_CYCLES = C_DRAIN_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    nrst,
    input  logic [ADDR_W-1:0]       fetch_addr,
    input  logic                    dbg_req,
    input  logic                    dbg_valid,
    input  logic [ADDR_W-1:0]       dbg_addr,
    input  logic [DATA_W-1:0]       dbg_data,
    input  logic                    dbg_last,
    input  logic                    dbg_abort,
    output logic                    dbg_ready,
    output logic                    fetch_stall,
    output logic                    restart,
    output logic                    mem_en,
    output logic                    mem_we,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [DATA_W-1:0]       mem_wdata,
    output logic [C_LOAD_CNT_W-1:0] load_count,
    output logic                    load_done
);

    localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    arb_state_e              r_state;
    arb_state_e              w_state_nxt;
    logic [DCNT_W-1:0]       r_drain_cnt;
    logic [C_LOAD_CNT_W-1:0] r_load_count;
    logic                    r_load_done;
    logic                    w_drain_last;
    logic                    w_wr;

    // A zero-length drain still spends one cycle in DRAIN.
    assign w_drain_last = (DRAIN_CYCLES <= 1) ? 1'b1
                        : (r_drain_cnt == DCNT_W'(DRAIN_CYCLES - 1));

    // Abort suppresses the write even when a word is offered.
    assign w_wr = (r_state == LOAD) && dbg_valid && !dbg_abort;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FETCH: begin
                if (dbg_req) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (dbg_abort)         w_state_nxt = RESTART;
                else if (w_drain_last) w_state_nxt = LOAD;
            end
            LOAD: begin
                if (dbg_abort)                  w_state_nxt = RESTART;
                else if (dbg_valid && dbg_last) w_state_nxt = RESTART;
            end
            RESTART: w_state_nxt = FETCH;
            default: w_state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state      <= FETCH;
            r_drain_cnt  <= '0;
            r_load_count <= '0;
            r_load_done  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_load_done <= w_wr && dbg_last;

            if (r_state == DRAIN && !w_drain_last && !dbg_abort)
                r_drain_cnt <= r_drain_cnt + DCNT_W'(1);
            else
                r_drain_cnt <= '0;

            if (r_state == FETCH && dbg_req)
                r_load_count <= '0;
            else if (w_wr && r_load_count != {C_LOAD_CNT_W{1'b1}})
                r_load_count <= r_load_count + C_LOAD_CNT_W'(1);
        end
    end

    assign dbg_ready   = (r_state == LOAD);
    assign fetch_stall = (r_state != FETCH);
    assign restart     = (r_state == RESTART);
    assign mem_en      = (r_state == FETCH) || w_wr;
    assign mem_we      = w_wr;
    assign mem_addr    = w_wr ? dbg_addr : fetch_addr;
    assign mem_wdata   = w_wr ? dbg_data : '0;
    assign load_count  = r_load_count;
    assign load_done   = r_load_done;

endmodule

`default_nettype wire

// File: tb/tb_imem_port_arbiter.sv
// ============================================================================
// Module      : tb_imem_port_arbiter
// Description : Directed self-checking bench for imem_port_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_port_arbiter;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    logic              clk;
    logic              nrst;
    logic [ADDR_W-1:0] fetch_addr;
    logic              dbg_req;
    logic              dbg_valid;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_data;
    logic              dbg_last;
    logic              dbg_abort;

    logic              dbg_ready, fetch_stall, restart, mem_en, mem_we, load_done;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [15:0]       load_count;

    logic              z_dbg_ready, z_fetch_stall, z_restart, z_mem_en, z_mem_we, z_load_done;
    logic [ADDR_W-1:0] z_mem_addr;
    logic [DATA_W-1:0] z_mem_wdata;
    logic [15:0]       z_load_count;

    int n_checks = 0;
    int n_fail   = 0;

    imem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DRAIN_CYCLES(2)) u_dut (
        .clk(clk), .nrst(nrst), .fetch_addr(fetch_addr), .dbg_req(dbg_req),
        .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .dbg_last(dbg_last), .dbg_abort(dbg_abort), .dbg_ready(dbg_ready),
        .fetch_stall(fetch_stall), .restart(restart), .mem_en(mem_en),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .load_count(load_count), .load_done(load_done)
    );

    // Zero-length drain variant sharing the same stimulus.
    imem_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DRAIN_CYCLES(0)) u_dut_d0 (
        .clk(clk), .nrst(nrst), .fetch_addr(fetch_addr), .dbg_req(dbg_req),
        .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
        .dbg_last(dbg_last), .dbg_abort(dbg_abort), .dbg_ready(z_dbg_ready),
        .fetch_stall(z_fetch_stall), .restart(z_restart), .mem_en(z_mem_en),
        .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_wdata(z_mem_wdata),
        .load_count(z_load_count), .load_done(z_load_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench one step into the second DRAIN cycle.
    task automatic enter_load;
        tick;
        dbg_req = 1'b1;
        tick;
        dbg_req = 1'b0;
        tick;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] bp_pat;
        bp_pat     = 4'b1001;
        nrst       = 1'b0;
        fetch_addr = 32'h1234;
        dbg_req    = 1'b0;
        dbg_valid  = 1'b0;
        dbg_addr   = '0;
        dbg_data   = '0;
        dbg_last   = 1'b0;
        dbg_abort  = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        dbg_req = 1'b1;
        dbg_valid = 1'b1;
        #1;
        chk("rst_stall",  fetch_stall, 0);
        chk("rst_ready",  dbg_ready,   0);
        chk("rst_we",     mem_we,      0);
        chk("rst_en",     mem_en,      1);
        chk("rst_addr",   mem_addr,    32'h1234);
        chk("rst_cnt",    load_count,  0);
        chk("rst_done",   load_done,   0);
        chk("rst_restart", restart,    0);
        dbg_req   = 1'b0;
        dbg_valid = 1'b0;
        nrst      = 1'b1;

        // Fetch-only sweep
        for (int i = 0; i < 8; i++) begin
            tick;
            fetch_addr = i;
            #1;
            chk("sweep_addr",  mem_addr,    i);
            chk("sweep_we",    mem_we,      0);
            chk("sweep_stall", fetch_stall, 0);
        end

        // Zero drain cycles, then abort from DRAIN/LOAD
        tick;
        dbg_req = 1'b1;
        #1;
        chk("d0_fetch_stall", z_fetch_stall, 0);
        tick;
        dbg_req = 1'b0;
        #1;
        chk("d0_drain_stall", z_fetch_stall, 1);
        chk("d0_drain_ready", z_dbg_ready,   0);
        chk("d2_drain1_en",   mem_en,        0);
        tick;
        chk("d0_load_ready",  z_dbg_ready,   1);
        chk("d2_drain2_ready", dbg_ready,    0);
        dbg_abort = 1'b1;
        tick;
        dbg_abort = 1'b0;
        #1;
        chk("drain_abort_restart", restart,   1);
        chk("drain_abort_en",      mem_en,    0);
        chk("drain_abort_done",    load_done, 0);
        chk("d0_abort_restart",    z_restart, 1);
        tick;
        chk("drain_abort_back", fetch_stall, 0);
        chk("drain_abort_rs0",  restart,     0);

        // Abort in FETCH is ignored
        dbg_abort = 1'b1;
        tick;
        dbg_abort = 1'b0;
        #1;
        chk("fetch_abort_stall",   fetch_stall, 0);
        chk("fetch_abort_restart", restart,     0);

        // Normal three-word load
        repeat (5) tick;
        dbg_req = 1'b1;
        #1;
        chk("nl_req_en", mem_en, 1);
        tick;
        dbg_req = 1'b0;
        #1;
        chk("nl_d1_stall", fetch_stall, 1);
        chk("nl_d1_en",    mem_en,      0);
        chk("nl_d1_cnt",   load_count,  0);
        tick;
        chk("nl_d2_ready", dbg_ready, 0);
        chk("nl_d2_en",    mem_en,    0);
        tick;
        dbg_valid = 1'b1;
        dbg_addr  = 0;
        dbg_data  = 32'hAA;
        #1;
        chk("nl_w0_ready", dbg_ready, 1);
        chk("nl_w0_we",    mem_we,    1);
        chk("nl_w0_en",    mem_en,    1);
        chk("nl_w0_addr",  mem_addr,  0);
        chk("nl_w0_data",  mem_wdata, 32'hAA);
        tick;
        dbg_addr = 1;
        dbg_data = 32'hBB;
        #1;
        chk("nl_w1_data", mem_wdata,  32'hBB);
        chk("nl_w1_cnt",  load_count, 1);
        tick;
        dbg_addr = 2;
        dbg_data = 32'hCC;
        dbg_last = 1'b1;
        #1;
        chk("nl_w2_addr", mem_addr,  2);
        chk("nl_w2_data", mem_wdata, 32'hCC);
        tick;
        dbg_valid = 1'b0;
        dbg_last  = 1'b0;
        #1;
        chk("nl_cnt",     load_count, 3);
        chk("nl_done",    load_done,  1);
        chk("nl_restart", restart,    1);
        chk("nl_rs_en",   mem_en,     0);
        chk("nl_rs_wd",   mem_wdata,  0);
        tick;
        chk("nl_done_clr",    load_done,   0);
        chk("nl_restart_clr", restart,     0);
        chk("nl_resume",      fetch_stall, 0);
        chk("nl_resume_addr", mem_addr,    7);

        // Abort coincident with the second word
        enter_load;
        tick;
        dbg_valid = 1'b1;
        dbg_addr  = 10;
        dbg_data  = 32'h11;
        #1;
        chk("ab_w0_we", mem_we, 1);
        tick;
        dbg_addr  = 11;
        dbg_data  = 32'h22;
        dbg_abort = 1'b1;
        #1;
        chk("ab_we",  mem_we,    0);
        chk("ab_en",  mem_en,    0);
        chk("ab_wd",  mem_wdata, 0);
        tick;
        dbg_valid = 1'b0;
        dbg_abort = 1'b0;
        #1;
        chk("ab_restart", restart,    1);
        chk("ab_done",    load_done,  0);
        chk("ab_cnt",     load_count, 1);
        tick;
        chk("ab_restart_once", restart,   0);
        chk("ab_done_never",   load_done, 0);

        // Backpressure gaps
        enter_load;
        for (int i = 0; i < 4; i++) begin
            tick;
            dbg_valid = bp_pat[i];
            dbg_addr  = 20 + i;
            dbg_data  = i + 1;
            dbg_last  = (i == 3);
            #1;
            chk("bp_we",    mem_we,      bp_pat[i]);
            chk("bp_stall", fetch_stall, 1);
        end
        tick;
        dbg_valid = 1'b0;
        dbg_last  = 1'b0;
        #1;
        chk("bp_cnt",  load_count, 2);
        chk("bp_done", load_done,  1);
        tick;

        // Reset mid-LOAD after two words
        enter_load;
        tick;
        dbg_valid = 1'b1;
        dbg_addr  = 30;
        dbg_data  = 32'h33;
        tick;
        dbg_addr  = 31;
        dbg_data  = 32'h44;
        tick;
        #1;
        chk("mr_cnt_pre", load_count, 2);
        nrst = 1'b0;
        #1;
        chk("mr_stall",   fetch_stall, 0);
        chk("mr_ready",   dbg_ready,   0);
        chk("mr_we",      mem_we,      0);
        chk("mr_en",      mem_en,      1);
        chk("mr_addr",    mem_addr,    7);
        chk("mr_wdata",   mem_wdata,   0);
        chk("mr_cnt",     load_count,  0);
        chk("mr_restart", restart,     0);
        chk("mr_done",    load_done,   0);
        dbg_valid = 1'b0;
        tick;
        nrst = 1'b1;
        tick;
        chk("mr_post_restart", restart,     0);
        chk("mr_post_stall",   fetch_stall, 0);

        // Saturation
        enter_load;
        dbg_valid = 1'b1;
        dbg_data  = 32'h5A;
        repeat (65540) tick;
        chk("sat_cnt", load_count, 16'hFFFF);
        dbg_last = 1'b1;
        tick;
        dbg_valid = 1'b0;
        dbg_last  = 1'b0;
        #1;
        chk("sat_cnt_final", load_count, 16'hFFFF);
        chk("sat_done",      load_done,  1);
        tick;

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
